// File: rtl/hfclk_seq_if.sv
// hfclk_seq_if -- request/status bundle between the PMU side and hfclk_seq.
//   clkhf_powerup_req, clkhf_enable_req : PMU requests (req = both high)
//   hf_ready_async                      : HFOSC ready flag, asynchronous
//   fault_clr                           : one-cycle pulse clearing seq_fault
//   hfosc_powerup, hfosc_enable         : HFOSC CLKHFPU / CLKHFEN controls
//   clk_sel                             : 1 = core on HF clock
//   seq_busy, seq_fault, state_dbg      : status and debug
// The master modport drives the requests; the slave modport is the sequencer.
interface hfclk_seq_if;
    logic       clkhf_powerup_req;
    logic       clkhf_enable_req;
    logic       hf_ready_async;
    logic       fault_clr;
    logic       hfosc_powerup;
    logic       hfosc_enable;
    logic       clk_sel;
    logic       seq_busy;
    logic       seq_fault;
    logic [2:0] state_dbg;

    modport master (
        output clkhf_powerup_req, clkhf_enable_req, hf_ready_async, fault_clr,
        input  hfosc_powerup, hfosc_enable, clk_sel, seq_busy, seq_fault, state_dbg
    );

    modport slave (
        input  clkhf_powerup_req, clkhf_enable_req, hf_ready_async, fault_clr,
        output hfosc_powerup, hfosc_enable, clk_sel, seq_busy, seq_fault, state_dbg
    );
endinterface

// File: rtl/hfclk_seq.sv
// hfclk_seq -- HFOSC power-up and core clock switchover sequencer.
// Runs on the always-on slow clock. Powers the HFOSC up, waits for its ready
// flag, holds a settle window, then selects the fast clock. On request drop or
// ready loss it returns to the slow clock and waits a guard window before
// powering the oscillator down.
// Ports:
//   clk    : always-on slow clock, all state on posedge
//   reset  : asynchronous, active-high; clears all state and outputs
//   bus    : hfclk_seq_if.slave (requests in, HFOSC controls/status out)
module hfclk_seq #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int GUARD_CYCLES   = 4,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    hfclk_seq_if.slave  bus
);

    localparam logic [2:0] ST_OFF    = 3'd0;
    localparam logic [2:0] ST_WAKE   = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_END  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_END   = CNT_W'(GUARD_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             rdy_s;
    logic             req;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             armed_q, armed_d;
    logic             fault_set;
    logic             fault_q, fault_d;
    logic             pu_q, en_q, sel_q, busy_q;

    // Enable without powerup (or the reverse) is treated as no request.
    assign req     = bus.clkhf_powerup_req & bus.clkhf_enable_req;
    assign rdy_s   = sync_q[1];
    // Saturating increment: the counter never wraps.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        armed_d   = armed_q;
        fault_set = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (!req) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = ST_WAKE;
                    cnt_d   = '0;
                end
            end
            ST_WAKE: begin
                cnt_d = cnt_inc;
                if (!req) begin
                    state_d = ST_OFF;
                end else if (rdy_s) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_END) begin
                    // Disarm so a stuck oscillator is not retried until req drops.
                    state_d   = ST_OFF;
                    fault_set = 1'b1;
                    armed_d   = 1'b0;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_inc;
                if (!req) begin
                    state_d = ST_OFF;
                end else if (!rdy_s) begin
                    state_d = ST_WAKE;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_END) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Request drop and ready loss share one DRAIN entry.
                if (!req || !rdy_s) begin
                    state_d   = ST_DRAIN;
                    cnt_d     = '0;
                    fault_set = !rdy_s;
                end
            end
            ST_DRAIN: begin
                // Guard window always completes; request changes are ignored.
                cnt_d = cnt_inc;
                if (cnt_q == GUARD_END) begin
                    state_d = ST_OFF;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // A new fault wins over a clear in the same cycle.
    assign fault_d = fault_set | (fault_q & ~bus.fault_clr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b00;
            state_q <= ST_OFF;
            cnt_q   <= '0;
            armed_q <= 1'b1;
            fault_q <= 1'b0;
            pu_q    <= 1'b0;
            en_q    <= 1'b0;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], bus.hf_ready_async};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            fault_q <= fault_d;
            // Outputs decode the next state so they move on the same edge.
            pu_q    <= (state_d != ST_OFF);
            en_q    <= (state_d == ST_SETTLE) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
            sel_q   <= (state_d == ST_RUN);
            busy_q  <= (state_d == ST_WAKE) || (state_d == ST_SETTLE) || (state_d == ST_DRAIN);
        end
    end

    assign bus.hfosc_powerup = pu_q;
    assign bus.hfosc_enable  = en_q;
    assign bus.clk_sel       = sel_q;
    assign bus.seq_busy      = busy_q;
    assign bus.seq_fault     = fault_q;
    assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_hfclk_seq.sv
module tb_hfclk_seq;

    localparam logic [2:0] OFF    = 3'd0;
    localparam logic [2:0] WAKE   = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] RUN    = 3'd3;
    localparam logic [2:0] DRAIN  = 3'd4;

    typedef struct {
        logic       pu;
        logic       en;
        logic       rdy;
        logic       fclr;
        int         n;
        logic [2:0] st;
        logic       f;
    } vec_t;

    typedef struct {
        string      nm;
        logic [7:0] v;
    } exp_t;

    logic clk;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t tbl[$];
    exp_t sb[$];

    hfclk_seq_if bus ();

    hfclk_seq #(
        .SETTLE_CYCLES (16),
        .TIMEOUT_CYCLES(255),
        .GUARD_CYCLES  (4),
        .CNT_W         (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Expected {state, powerup, enable, sel, busy, fault} for a state.
    function automatic logic [7:0] exp_of(input logic [2:0] st, input logic f);
        logic [3:0] o;
        case (st)
            WAKE:    o = 4'b1001;
            SETTLE:  o = 4'b1101;
            RUN:     o = 4'b1110;
            DRAIN:   o = 4'b1101;
            default: o = 4'b0000;
        endcase
        return {st, o, f};
    endfunction

    function automatic logic [7:0] obs();
        return {bus.state_dbg, bus.hfosc_powerup, bus.hfosc_enable,
                bus.clk_sel, bus.seq_busy, bus.seq_fault};
    endfunction

    function automatic vec_t mkv(input logic pu, input logic en, input logic rdy,
                                 input logic fclr, input int n,
                                 input logic [2:0] st, input logic f);
        vec_t v;
        v.pu = pu; v.en = en; v.rdy = rdy; v.fclr = fclr;
        v.n = n; v.st = st; v.f = f;
        return v;
    endfunction

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %b want %b (state,pu,en,sel,busy,fault)", nm, got, want);
        end
    endtask

    task automatic check_bit(input string nm, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %b want %b", nm, got, want);
        end
    endtask

    task automatic drive(input logic pu, input logic en, input logic rdy, input logic fclr);
        bus.clkhf_powerup_req = pu;
        bus.clkhf_enable_req  = en;
        bus.hf_ready_async    = rdy;
        bus.fault_clr         = fclr;
    endtask

    // Queue the expectation, advance one edge, then retire it against the DUT.
    task automatic tick(input string nm, input logic [2:0] st, input logic f);
        exp_t e;
        e.nm = nm;
        e.v  = exp_of(st, f);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: got empty scoreboard want entry", nm);
        end else begin
            e = sb.pop_front();
            check(e.nm, obs(), e.v);
        end
    endtask

    task automatic async_reset_check(input string nm);
        #3;
        reset = 1'b1;
        #1;
        check(nm, obs(), 8'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Main sequences: power-up latency, req drop, re-entry, ready loss, fault clear.
        tbl.push_back(mkv(1, 1, 1, 0,  2, WAKE,   0));
        tbl.push_back(mkv(1, 1, 1, 0, 16, SETTLE, 0));
        tbl.push_back(mkv(1, 1, 1, 0,  4, RUN,    0));
        tbl.push_back(mkv(0, 1, 1, 0,  1, DRAIN,  0));
        tbl.push_back(mkv(1, 1, 1, 0,  3, DRAIN,  0));
        tbl.push_back(mkv(1, 1, 1, 0,  1, OFF,    0));
        tbl.push_back(mkv(1, 1, 1, 0,  1, WAKE,   0));
        tbl.push_back(mkv(1, 1, 1, 0, 16, SETTLE, 0));
        tbl.push_back(mkv(1, 1, 1, 0,  2, RUN,    0));
        tbl.push_back(mkv(1, 1, 0, 0,  2, RUN,    0));
        tbl.push_back(mkv(1, 1, 0, 0,  4, DRAIN,  1));
        tbl.push_back(mkv(1, 1, 0, 0,  1, OFF,    1));
        tbl.push_back(mkv(1, 1, 0, 0,  1, WAKE,   1));
        tbl.push_back(mkv(1, 1, 0, 1,  1, WAKE,   0));
        tbl.push_back(mkv(1, 1, 0, 0,  1, WAKE,   0));
        tbl.push_back(mkv(0, 0, 0, 0,  1, OFF,    0));
        tbl.push_back(mkv(1, 0, 0, 0,  2, OFF,    0));

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", obs(), 8'd0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].pu, tbl[i].en, tbl[i].rdy, tbl[i].fclr);
            for (int k = 0; k < tbl[i].n; k++) begin
                tick($sformatf("row%0d_edge%0d", i, k), tbl[i].st, tbl[i].f);
            end
        end

        // WAKE timeout with a clear pulse landing on the setting edge.
        drive(1, 1, 0, 0);
        for (int k = 0; k < 255; k++) tick($sformatf("timeout_wake%0d", k), WAKE, 0);
        drive(1, 1, 0, 1);
        tick("timeout_off_set_beats_clr", OFF, 1);
        drive(1, 1, 0, 0);
        for (int k = 0; k < 5; k++) tick($sformatf("timeout_disarmed%0d", k), OFF, 1);
        drive(0, 0, 0, 0);
        tick("timeout_req_low", OFF, 1);
        drive(1, 1, 0, 0);
        tick("timeout_rearm_wake", WAKE, 1);
        drive(0, 0, 0, 1);
        tick("timeout_clr", OFF, 0);

        // Ready blip in SETTLE restarts the settle count from zero.
        drive(0, 0, 1, 0);
        tick("blip_prefill0", OFF, 0);
        tick("blip_prefill1", OFF, 0);
        drive(1, 1, 1, 0);
        tick("blip_wake", WAKE, 0);
        tick("blip_settle0", SETTLE, 0);
        for (int k = 1; k <= 8; k++) tick($sformatf("blip_settle%0d", k), SETTLE, 0);
        drive(1, 1, 0, 0);
        tick("blip_settle9", SETTLE, 0);
        drive(1, 1, 1, 0);
        tick("blip_settle10", SETTLE, 0);
        tick("blip_back_wake", WAKE, 0);
        for (int k = 0; k < 16; k++) tick($sformatf("blip_resettle%0d", k), SETTLE, 0);
        tick("blip_run", RUN, 0);

        // Asynchronous reset in DRAIN with a fault pending, then in SETTLE.
        drive(1, 1, 0, 0);
        tick("rst_drain_run0", RUN, 0);
        tick("rst_drain_run1", RUN, 0);
        tick("rst_drain_entry", DRAIN, 1);
        async_reset_check("reset_in_drain");
        drive(1, 1, 1, 0);
        tick("rst_settle_wake0", WAKE, 0);
        tick("rst_settle_wake1", WAKE, 0);
        tick("rst_settle_s0", SETTLE, 0);
        tick("rst_settle_s1", SETTLE, 0);
        async_reset_check("reset_in_settle");

        // Random stress on the output ordering invariants.
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 15) != 0, $urandom_range(0, 15) != 0,
                  $urandom_range(0, 31) != 0, $urandom_range(0, 15) == 0);
            @(posedge clk);
            #1;
            check_bit("stress_sel_implies_en", bus.clk_sel & ~bus.hfosc_enable, 1'b0);
            check_bit("stress_en_implies_pu", bus.hfosc_enable & ~bus.hfosc_powerup, 1'b0);
            check_bit("stress_state_legal", bus.state_dbg > DRAIN, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
